fetch_prefetch_queue: RTL and testbench

- Sits between the instruction memory port and the IF stage of the 5-stage pipeline.
- Issues sequential word fetches ahead of IF and buffers returned instructions, each tagged with its 15-bit PC, in an in-order FIFO.
- Presents one instruction per cycle to IF under a valid/ready handshake. IF deasserts ready when the hazard unit or an exception stalls the pipeline.
- Flushes on branch/jal/jalr redirect and discards in-flight responses belonging to the wrong path.

---
 rtl/fetch_prefetch_queue_pkg.sv | 21 ++
 rtl/fetch_prefetch_queue_sync_fifo.sv | 77 +++++++
 rtl/fetch_prefetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared fetch-path definitions: PC/instruction widths, the fetch FSM
// state type and the PC alignment helper.
package fetch_prefetch_queue_pkg;

    localparam int PC_W    = 15;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
    localparam int ENTRY_W = PC_W + INSTR_W;

    localparam logic [PC_W-1:0] PC_ALIGN_MASK = ~PC_W'(PC_STEP - 1);

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with push/pop/clear and an occupancy count; DEPTH must be
// a power of two so the pointers wrap naturally.
module fetch_prefetch_queue_sync_fifo #(
    parameter int WIDTH = 47,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        do_push  = push && !clear && !full;
        do_pop   = pop && !clear && (count_q != '0);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !clear && full));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches ahead of IF,
// buffers tagged responses in order and discards wrong-path returns after a redirect.
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 4,
    parameter logic [PC_W-1:0] RESET_PC        = 15'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [PC_W-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int INF_W = $clog2(MAX_OUTSTANDING+1);
    localparam int OCC_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]    resp_pc_q, resp_pc_d;
    logic [INF_W-1:0]   inflight_q, inflight_d;
    logic [INF_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [INF_W-1:0]   inflight_after_resp;
    logic [CNT_W-1:0]   fifo_count;
    logic [OCC_W-1:0]   occupancy;
    logic [ENTRY_W-1:0] head_entry;
    logic               req_fire;
    logic               resp_drop;
    logic               fifo_push;
    logic               fifo_pop;

    // Credit check counts buffered entries plus live (non-dropped) requests,
    // so every live response is guaranteed a FIFO slot.
    always_comb begin
        occupancy      = OCC_W'(fifo_count) + OCC_W'(inflight_q - drop_cnt_q);
        imem_req_valid = (state_q == RUN) && !redirect_valid
                         && (inflight_q < INF_W'(MAX_OUTSTANDING))
                         && (occupancy < OCC_W'(DEPTH));
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_drop      = imem_resp_valid && (drop_cnt_q != '0);
        fifo_push      = imem_resp_valid && !resp_drop && !redirect_valid;
        if_valid       = (fifo_count != '0);
        fifo_pop       = if_valid && if_ready && !redirect_valid;
        if_pc          = head_entry[ENTRY_W-1:INSTR_W];
        if_instr       = head_entry[INSTR_W-1:0];
    end

    always_comb begin
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // A redirect turns every request still pending after this cycle's
    // response into a drop, and restarts both PCs at the aligned target.
    always_comb begin
        inflight_after_resp = inflight_q - INF_W'(imem_resp_valid);
        inflight_d          = inflight_after_resp + INF_W'(req_fire);
        fetch_pc_d          = fetch_pc_q;
        resp_pc_d           = resp_pc_q;
        drop_cnt_d          = drop_cnt_q;
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            resp_pc_d  = align_pc(redirect_pc);
            drop_cnt_d = inflight_after_resp;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - INF_W'(1);
            end
            if (fifo_push) begin
                resp_pc_d = resp_pc_q + PC_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_prefetch_queue_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (fifo_push),
        .push_data ({resp_pc_q, imem_resp_data}),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    a_counter_order: assert property (@(posedge clk) disable iff (reset)
        (drop_cnt_q <= inflight_q) && (inflight_q <= INF_W'(MAX_OUTSTANDING)));

    a_resp_tracked: assert property (@(posedge clk) disable iff (reset)
        imem_resp_valid |-> (inflight_q != '0));

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for the prefetch queue: a fixed vector table for the start-up and stall
// sequence, directed corner sequences and a randomized run against a queue model.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;
    localparam int MAXO  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [14:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [14:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [14:0] if_pc;
    logic [31:0] if_instr;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (15'h0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic        resp_v;
        logic [14:0] resp_a;
        logic        if_rdy;
        logic        e_ifv;
        logic [14:0] e_pc;
        logic        e_reqv;
        logic [14:0] e_addr;
    } vec_t;

    typedef struct {
        logic [14:0] addr;
        bit          wanted;
    } pend_t;

    vec_t        vecs [15];
    pend_t       pend [$];
    logic [14:0] mq [$];
    logic [14:0] m_fetch;
    bit          m_run   = 1'b0;
    bit          m_known = 1'b0;
    bit          rsp_en  = 1'b0;

    // Memory contents are a pure function of the word address.
    function automatic logic [31:0] memWord(input logic [14:0] a);
        return {2'b10, a, ~a};
    endfunction

    function automatic int wantedCount();
        int n = 0;
        foreach (pend[i]) if (pend[i].wanted) n++;
        return n;
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        compare($sformatf("tbl%0d if_valid", idx), 32'(if_valid), 32'(v.e_ifv));
        if (v.e_ifv) begin
            compare($sformatf("tbl%0d if_pc", idx), 32'(if_pc), 32'(v.e_pc));
            compare($sformatf("tbl%0d if_instr", idx), if_instr, memWord(v.e_pc));
        end
        compare($sformatf("tbl%0d req_valid", idx), 32'(imem_req_valid), 32'(v.e_reqv));
        compare($sformatf("tbl%0d req_addr", idx), 32'(imem_req_addr), 32'(v.e_addr));
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        redirect_valid  = 1'b0;
        redirect_pc     = 15'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = v.resp_v;
        imem_resp_data  = v.resp_v ? memWord(v.resp_a) : 32'h0;
        if_ready        = v.if_rdy;
        @(negedge clk);
        checkOutput(v, idx);
        @(posedge clk);
        #1;
    endtask

    // One clock against the queue model; the memory answers the oldest
    // outstanding request whenever rsp_en allows it.
    task automatic modelCycle();
        bit    have_resp;
        bit    exp_req;
        bit    hs;
        pend_t front;
        have_resp       = rsp_en && !reset && (pend.size() > 0);
        imem_resp_valid = have_resp;
        imem_resp_data  = have_resp ? memWord(pend[0].addr) : 32'h0;
        exp_req = m_known && m_run && !redirect_valid && (pend.size() < MAXO)
                  && ((mq.size() + wantedCount()) < DEPTH);
        @(negedge clk);
        if (m_known) begin
            compare("mdl req_valid", 32'(imem_req_valid), 32'(exp_req));
            compare("mdl req_addr", 32'(imem_req_addr), 32'(m_fetch));
            compare("mdl if_valid", 32'(if_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                compare("mdl if_pc", 32'(if_pc), 32'(mq[0]));
                compare("mdl if_instr", if_instr, memWord(mq[0]));
            end
        end
        hs = exp_req && imem_req_ready;
        if (reset) begin
            pend.delete();
            mq.delete();
            m_fetch = 15'h0000;
            m_run   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            if (have_resp) front = pend.pop_front();
            if (redirect_valid) begin
                mq.delete();
                foreach (pend[i]) pend[i].wanted = 1'b0;
                m_fetch = redirect_pc & 15'h7FFC;
            end else begin
                if ((mq.size() > 0) && if_ready) void'(mq.pop_front());
                if (have_resp && front.wanted) mq.push_back(front.addr);
                if (hs) begin
                    pend.push_back('{m_fetch, 1'b1});
                    m_fetch = m_fetch + 15'd4;
                end
            end
            m_run = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic resetModel();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 15'h0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        rsp_en         = 1'b0;
        modelCycle();
        reset = 1'b0;
    endtask

    task automatic runUntilValid(input int budget);
        for (int k = 0; k < budget && !if_valid; k++) modelCycle();
    endtask

    initial begin
        logic [14:0] got [$];
        logic [14:0] wrap_exp [3];
        wrap_exp = '{15'h7FF8, 15'h7FFC, 15'h0000};

        vecs[0]  = '{1'b0, 15'h000, 1'b1, 1'b0, 15'h000, 1'b0, 15'h000};
        vecs[1]  = '{1'b0, 15'h000, 1'b1, 1'b0, 15'h000, 1'b1, 15'h000};
        vecs[2]  = '{1'b1, 15'h000, 1'b1, 1'b0, 15'h000, 1'b1, 15'h004};
        vecs[3]  = '{1'b1, 15'h004, 1'b1, 1'b1, 15'h000, 1'b1, 15'h008};
        vecs[4]  = '{1'b1, 15'h008, 1'b1, 1'b1, 15'h004, 1'b1, 15'h00C};
        vecs[5]  = '{1'b1, 15'h00C, 1'b0, 1'b1, 15'h008, 1'b1, 15'h010};
        vecs[6]  = '{1'b1, 15'h010, 1'b0, 1'b1, 15'h008, 1'b1, 15'h014};
        vecs[7]  = '{1'b1, 15'h014, 1'b0, 1'b1, 15'h008, 1'b0, 15'h018};
        vecs[8]  = '{1'b0, 15'h000, 1'b0, 1'b1, 15'h008, 1'b0, 15'h018};
        vecs[9]  = '{1'b0, 15'h000, 1'b1, 1'b1, 15'h008, 1'b0, 15'h018};
        vecs[10] = '{1'b0, 15'h000, 1'b1, 1'b1, 15'h00C, 1'b1, 15'h018};
        vecs[11] = '{1'b1, 15'h018, 1'b1, 1'b1, 15'h010, 1'b1, 15'h01C};
        vecs[12] = '{1'b1, 15'h01C, 1'b1, 1'b1, 15'h014, 1'b1, 15'h020};
        vecs[13] = '{1'b1, 15'h020, 1'b1, 1'b1, 15'h018, 1'b1, 15'h024};
        vecs[14] = '{1'b1, 15'h024, 1'b1, 1'b1, 15'h01C, 1'b1, 15'h028};

        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 15'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        if_ready        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] table: start-up, stall and drain");
        for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

        $display("[TB] redirect with three requests in flight");
        resetModel();
        compare("rst if_valid", 32'(if_valid), 32'h0);
        compare("rst req_valid", 32'(imem_req_valid), 32'h0);
        compare("rst req_addr", 32'(imem_req_addr), 32'h0);
        repeat (4) modelCycle();
        redirect_valid = 1'b1;
        redirect_pc    = 15'h1A3;
        modelCycle();
        redirect_valid = 1'b0;
        #1;
        compare("redir if_valid", 32'(if_valid), 32'h0);
        compare("redir req_valid", 32'(imem_req_valid), 32'h1);
        compare("redir req_addr", 32'(imem_req_addr), 32'h1A0);
        rsp_en = 1'b1;
        runUntilValid(20);
        compare("redir first valid", 32'(if_valid), 32'h1);
        compare("redir first pc", 32'(if_pc), 32'h1A0);

        $display("[TB] redirect colliding with response and pop");
        resetModel();
        if_ready = 1'b0;
        rsp_en   = 1'b1;
        repeat (3) modelCycle();
        rsp_en = 1'b0;
        repeat (2) modelCycle();
        redirect_valid = 1'b1;
        redirect_pc    = 15'h0245;
        if_ready       = 1'b1;
        rsp_en         = 1'b1;
        modelCycle();
        redirect_valid = 1'b0;
        #1;
        compare("collide if_valid", 32'(if_valid), 32'h0);
        compare("collide req_addr", 32'(imem_req_addr), 32'h244);
        runUntilValid(20);
        compare("collide first pc", 32'(if_pc), 32'h244);

        $display("[TB] redirect during BOOT and PC wrap");
        resetModel();
        redirect_valid = 1'b1;
        redirect_pc    = 15'h7FF9;
        modelCycle();
        redirect_valid = 1'b0;
        #1;
        compare("wrap req_valid", 32'(imem_req_valid), 32'h1);
        compare("wrap req_addr", 32'(imem_req_addr), 32'h7FF8);
        rsp_en = 1'b1;
        for (int k = 0; k < 40 && got.size() < 3; k++) begin
            if (if_valid && if_ready) got.push_back(if_pc);
            modelCycle();
        end
        compare("wrap pops", 32'(got.size()), 32'd3);
        for (int i = 0; i < got.size() && i < 3; i++)
            compare($sformatf("wrap pc%0d", i), 32'(got[i]), 32'(wrap_exp[i]));

        $display("[TB] long stall then reset mid-operation");
        if_ready = 1'b0;
        repeat (20) modelCycle();
        compare("stall req_valid", 32'(imem_req_valid), 32'h0);
        reset = 1'b1;
        modelCycle();
        reset = 1'b0;
        #1;
        compare("midrst if_valid", 32'(if_valid), 32'h0);
        compare("midrst req_valid", 32'(imem_req_valid), 32'h0);
        compare("midrst req_addr", 32'(imem_req_addr), 32'h0);
        if_ready = 1'b1;
        modelCycle();
        compare("midrst restart valid", 32'(imem_req_valid), 32'h1);
        compare("midrst restart addr", 32'(imem_req_addr), 32'h0);

        $display("[TB] randomized traffic");
        resetModel();
        for (int c = 0; c < 1500; c++) begin
            reset          = ($urandom_range(0, 499) == 0);
            redirect_valid = ($urandom_range(0, 31) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 15'(15'h7FF0 + 15'($urandom_range(0, 15)))
                                                         : 15'($urandom);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            rsp_en         = ($urandom_range(0, 9) < 6);
            if_ready       = ($urandom_range(0, 9) < 7);
            modelCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
